prog_loader: RTL and testbench

- Receives the program image byte stream from uart_rx while load mode is active and writes it word-by-word into SDRAM through the sdram_ctl write port.
- Parses a framed stream (length header, payload, optional checksum trailer) and reports progress and status for the debug display.
- Buffers assembled words in a small FIFO so that UART bytes are never stalled by SDRAM write latency.

---
 rtl/prog_loader.sv | 169 ++++++++++++++++
 tb/tb_prog_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: frames the UART load stream and writes words to sdram_ctl.
// Define PROG_LOADER_CSUM_EN to expect and verify the 16-bit checksum trailer.
`timescale 1ns/1ps
module prog_loader #(
  parameter int ADDR_WIDTH = 25,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  input  logic                  wr_ack,
  output logic [15:0]           word_count,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  typedef logic [PW:0] ptr_t;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
`ifdef PROG_LOADER_CSUM_EN
  localparam logic [3:0] S_CSUM_HI = 4'd5;
  localparam logic [3:0] S_CSUM_LO = 4'd6;
`endif
  localparam logic [3:0] S_DRAIN   = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;
  localparam logic [3:0] S_ERROR   = 4'd9;
`ifdef PROG_LOADER_CSUM_EN
  localparam logic [3:0] S_POST    = S_CSUM_HI;
`else
  localparam logic [3:0] S_POST    = S_DRAIN;
`endif

  logic [3:0]  state, state_n;
  logic        load_q;
  logic [7:0]  hi_q;
  logic [15:0] left;
  logic [15:0] word;
  logic [15:0] fifo_mem [FIFO_DEPTH];
  ptr_t        wptr, rptr, rptr_n;
  logic        rise, fall, in_sess, take;
  logic        empty, full, pop, pop_fifo;
  logic        push_try, ovf, push;
  logic        csum_bad, go_err;

  assign rise     = load_en & ~load_q;
  assign fall     = ~load_en & load_q;
  assign in_sess  = (state != S_IDLE) && (state != S_DONE) &&
                    (state != S_ERROR);
  assign take     = byte_valid & in_sess & (state != S_DRAIN) &
                    ~rise & ~fall;
  assign word     = {hi_q, byte_data};

  assign empty    = (wptr == rptr);
  assign full     = (wptr[PW] != rptr[PW]) &&
                    (wptr[PW-1:0] == rptr[PW-1:0]);
  assign pop      = wr_req & wr_ack;
  assign pop_fifo = pop & ~empty;
  assign rptr_n   = pop_fifo ? rptr + ptr_t'(1) : rptr;

  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push_try = take & (state == S_DATA_LO);
  assign ovf      = push_try & full & ~pop_fifo;
  assign push     = push_try & ~ovf;

`ifdef PROG_LOADER_CSUM_EN
  logic [15:0] csum;
  assign csum_bad = take && (state == S_CSUM_LO) && (word != csum);
`else
  assign csum_bad = 1'b0;
`endif

  always_comb begin
    state_n = state;
    if (rise) begin
      state_n = S_LEN_HI;
    end else if (fall && in_sess) begin
      state_n = S_ERROR;
    end else if (take) begin
      unique case (state)
        S_LEN_HI:  state_n = S_LEN_LO;
        S_LEN_LO:  state_n = (word == 16'd0) ? S_POST : S_DATA_HI;
        S_DATA_HI: state_n = S_DATA_LO;
        S_DATA_LO: state_n = ovf ? S_ERROR :
                             (left == 16'd1) ? S_POST : S_DATA_HI;
`ifdef PROG_LOADER_CSUM_EN
        S_CSUM_HI: state_n = S_CSUM_LO;
        S_CSUM_LO: state_n = csum_bad ? S_ERROR : S_DRAIN;
`endif
        default:   state_n = state;
      endcase
    end else if (state == S_DRAIN && empty && !wr_req) begin
      state_n = S_DONE;
    end
  end

  assign go_err = (state_n == S_ERROR) && (state != S_ERROR);
  assign busy   = in_sess;
  assign done   = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr[PW-1:0]] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      load_q     <= 1'b0;
      hi_q       <= '0;
      left       <= '0;
      wptr       <= '0;
      rptr       <= '0;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      err        <= '0;
`ifdef PROG_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      state  <= state_n;
      load_q <= load_en;
      if (take) hi_q <= byte_data;
      if (take && state == S_LEN_LO) left <= word;
      if (push) left <= left - 16'd1;
      if (rise) begin
        wptr       <= '0;
        rptr       <= '0;
        wr_req     <= 1'b0;
        word_count <= '0;
        err        <= '0;
`ifdef PROG_LOADER_CSUM_EN
        csum       <= '0;
`endif
      end else begin
        rptr <= rptr_n;
        // entering ERROR discards whatever is still queued
        if (go_err) wptr <= rptr_n;
        else if (push) wptr <= wptr + ptr_t'(1);
        if (ovf) err <= 2'd1;
        else if (csum_bad) err <= 2'd2;
        if (pop) begin
          wr_req     <= 1'b0;
          word_count <= word_count + 16'd1;
        end else if (!wr_req && !empty && in_sess && !go_err) begin
          wr_req  <= 1'b1;
          wr_data <= fifo_mem[rptr[PW-1:0]];
          wr_addr <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_count);
        end
`ifdef PROG_LOADER_CSUM_EN
        if (push) csum <= csum + word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vectors and corner sequences for prog_loader.
// Follows PROG_LOADER_CSUM_EN to pick the framed stream format.
`timescale 1ns/1ps
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        wr_req;
  logic [24:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack = 1'b0;
  logic [15:0] word_count;
  logic        busy, done;
  logic [1:0]  err;

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          ack_en = 1'b0;
  int          ack_dly = 3;
  int          cnt = 0;
  int          reqs = 0;
  int          unstable = 0;
  logic        prev_req = 1'b0;
  logic [24:0] h_addr = '0;
  logic [15:0] h_data = '0;
  logic [24:0] log_a[$];
  logic [15:0] log_d[$];

  // sdram_ctl model: ack ack_dly cycles after each request, log writes
  always @(negedge clk) begin
    if (wr_req && !prev_req) begin
      reqs++;
      h_addr = wr_addr;
      h_data = wr_data;
      cnt = 0;
    end else if (wr_req && (wr_addr != h_addr || wr_data != h_data)) begin
      unstable++;
    end
    if (wr_ack) begin
      wr_ack = 1'b0;
    end else if (ack_en && wr_req) begin
      cnt++;
      if (cnt >= ack_dly) begin
        wr_ack = 1'b1;
        log_a.push_back(wr_addr);
        log_d.push_back(wr_data);
      end
    end
    prev_req = wr_req;
  end

  typedef struct {
    string        name;
    logic [127:0] stream;
    int           nb;
    int           dly;
    int           exp_wc;
    logic         exp_done;
    logic [1:0]   exp_err;
    int           exp_reqs;
    logic [15:0]  d0;
    logic [15:0]  d1;
  } vec_t;

  vec_t vecs[4];
  int   nv;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "/timeout"}, 32'(n < 400), 32'd1);
  endtask

  task automatic start_session();
    @(negedge clk) load_en = 1'b0;
    @(negedge clk) load_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int rb, lb, ub;
    ack_en  = 1'b1;
    ack_dly = v.dly;
    rb = reqs;
    lb = log_a.size();
    ub = unstable;
    start_session();
    chk({v.name, "/busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < v.nb; i++) send(v.stream[8*(15-i) +: 8], 1);
    wait_idle(v.name);
    repeat (12) @(negedge clk);
    chk({v.name, "/word_count"}, 32'(word_count), 32'(v.exp_wc));
    chk({v.name, "/done"}, 32'(done), 32'(v.exp_done));
    chk({v.name, "/err"}, 32'(err), 32'(v.exp_err));
    chk({v.name, "/reqs"}, 32'(reqs - rb), 32'(v.exp_reqs));
    chk({v.name, "/stable"}, 32'(unstable - ub), 32'd0);
    chk({v.name, "/writes"}, 32'(log_a.size() - lb), 32'(v.exp_reqs));
    if (v.exp_reqs > 0 && log_a.size() > lb) begin
      chk({v.name, "/addr0"}, 32'(log_a[lb]), 32'd0);
      chk({v.name, "/data0"}, 32'(log_d[lb]), 32'(v.d0));
    end
    if (v.exp_reqs > 1 && log_a.size() > lb + 1) begin
      chk({v.name, "/addr1"}, 32'(log_a[lb+1]), 32'd1);
      chk({v.name, "/data1"}, 32'(log_d[lb+1]), 32'(v.d1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, lb;
    logic [7:0] ob[14];

`ifdef PROG_LOADER_CSUM_EN
    nv = 4;
    vecs[0] = '{"basic", 128'h0002_1234_ABCD_BE01_0000_0000_0000_0000,
                8, 3, 2, 1'b1, 2'd0, 2, 16'h1234, 16'hABCD};
    vecs[1] = '{"badsum", 128'h0002_1234_ABCD_BE02_0000_0000_0000_0000,
                8, 3, 2, 1'b0, 2'd2, 2, 16'h1234, 16'hABCD};
    vecs[2] = '{"zero", 128'h0000_0000_0000_0000_0000_0000_0000_0000,
                4, 3, 0, 1'b1, 2'd0, 0, 16'h0000, 16'h0000};
    vecs[3] = '{"n3", 128'h0003_0001_FFFF_8000_8000_0000_0000_0000,
                10, 1, 3, 1'b1, 2'd0, 3, 16'h0001, 16'hFFFF};
`else
    nv = 3;
    vecs[0] = '{"basic", 128'h0002_1234_ABCD_0000_0000_0000_0000_0000,
                6, 3, 2, 1'b1, 2'd0, 2, 16'h1234, 16'hABCD};
    vecs[1] = '{"zero", 128'h0000_0000_0000_0000_0000_0000_0000_0000,
                2, 3, 0, 1'b1, 2'd0, 0, 16'h0000, 16'h0000};
    vecs[2] = '{"n3", 128'h0003_0001_FFFF_8000_0000_0000_0000_0000,
                8, 1, 3, 1'b1, 2'd0, 3, 16'h0001, 16'hFFFF};
    vecs[3] = vecs[2];
`endif

    repeat (3) @(negedge clk);
    chk("rst/wr_req", 32'(wr_req), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/err", 32'(err), 32'd0);
    chk("rst/word_count", 32'(word_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < nv; i++) run_vec(vecs[i]);

    // overflow: N=6, one byte per cycle, acks withheld
    ack_en = 1'b0;
    rb = reqs;
    lb = log_a.size();
    ob[0] = 8'h00;
    ob[1] = 8'h06;
    for (int k = 0; k < 6; k++) begin
      ob[2+2*k] = 8'hA0;
      ob[3+2*k] = 8'(k + 1);
    end
    start_session();
    for (int i = 0; i < 14; i++) send(ob[i], 0);
    repeat (3) @(negedge clk);
    chk("ovf/err", 32'(err), 32'd1);
    chk("ovf/busy", 32'(busy), 32'd0);
    chk("ovf/done", 32'(done), 32'd0);
    chk("ovf/wr_req_held", 32'(wr_req), 32'd1);
    chk("ovf/word_count", 32'(word_count), 32'd0);
    ack_en  = 1'b1;
    ack_dly = 1;
    repeat (8) @(negedge clk);
    chk("ovf/wr_req_drop", 32'(wr_req), 32'd0);
    chk("ovf/word_count2", 32'(word_count), 32'd1);
    chk("ovf/reqs", 32'(reqs - rb), 32'd1);
    chk("ovf/writes", 32'(log_a.size() - lb), 32'd1);
    if (log_a.size() > lb)
      chk("ovf/data0", 32'(log_d[lb]), 32'h0000_A001);

    // abort: load_en falls with one request outstanding
    ack_en = 1'b0;
    rb = reqs;
    start_session();
    send(8'h00, 1);
    send(8'h04, 1);
    send(8'hA1, 1);
    send(8'h11, 1);
    repeat (3) @(negedge clk);
    chk("abort/wr_req", 32'(wr_req), 32'd1);
    load_en = 1'b0;
    @(negedge clk);
    chk("abort/busy", 32'(busy), 32'd0);
    chk("abort/held", 32'(wr_req), 32'd1);
    ack_en  = 1'b1;
    ack_dly = 2;
    repeat (8) @(negedge clk);
    chk("abort/wr_req_drop", 32'(wr_req), 32'd0);
    chk("abort/word_count", 32'(word_count), 32'd1);
    chk("abort/done", 32'(done), 32'd0);
    chk("abort/err", 32'(err), 32'd0);
    chk("abort/reqs", 32'(reqs - rb), 32'd1);
    load_en = 1'b1;
    @(negedge clk);
    chk("restart/word_count", 32'(word_count), 32'd0);
    chk("restart/busy", 32'(busy), 32'd1);

    // reset with a request outstanding, then stray bytes in IDLE
    ack_en = 1'b0;
    send(8'h00, 1);
    send(8'h02, 1);
    send(8'h12, 1);
    send(8'h34, 1);
    repeat (3) @(negedge clk);
    chk("rstmid/wr_req_pre", 32'(wr_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid/wr_req", 32'(wr_req), 32'd0);
    chk("rstmid/busy", 32'(busy), 32'd0);
    chk("rstmid/word_count", 32'(word_count), 32'd0);
    chk("rstmid/err", 32'(err), 32'd0);
    chk("rstmid/done", 32'(done), 32'd0);
    load_en = 1'b0;
    rst = 1'b0;
    ack_en = 1'b1;
    rb = reqs;
    send(8'h00, 1);
    send(8'h02, 1);
    send(8'h12, 1);
    send(8'h34, 1);
    repeat (6) @(negedge clk);
    chk("idle/reqs", 32'(reqs - rb), 32'd0);
    chk("idle/busy", 32'(busy), 32'd0);
    chk("idle/word_count", 32'(word_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
